// File: rtl/enc_param_ctrl.sv
// Rotary-encoder parameter editor.
// Browse a bank of shadow parameters, edit one with saturation, and push the
// committed value downstream over a valid/ready config write.
module enc_param_ctrl #(
  parameter int unsigned NUM_PARAMS = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned VAL_MAX    = 15,
  parameter int unsigned VAL_MIN    = 0,
  parameter int unsigned RESET_VAL  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step_cw,
  input  logic                          step_ccw,
  input  logic                          press_short,
  input  logic                          press_long,
  output logic                          cfg_valid,
  input  logic                          cfg_ready,
  output logic [$clog2(NUM_PARAMS)-1:0] cfg_addr,
  output logic [WIDTH-1:0]              cfg_data,
  output logic [1:0]                    mode,
  output logic [$clog2(NUM_PARAMS)-1:0] sel_idx,
  output logic [WIDTH-1:0]              disp_val,
  output logic [7:0]                    commit_cnt
);

  localparam int unsigned IW = $clog2(NUM_PARAMS);

  localparam logic [1:0] StBrowse = 2'b00;
  localparam logic [1:0] StEdit   = 2'b01;
  localparam logic [1:0] StCommit = 2'b10;

  localparam logic [WIDTH-1:0] ValMax   = WIDTH'(VAL_MAX);
  localparam logic [WIDTH-1:0] ValMin   = WIDTH'(VAL_MIN);
  localparam logic [WIDTH-1:0] ValReset = WIDTH'(RESET_VAL);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] edit_q, edit_d;
  logic [WIDTH-1:0] shadow_q [NUM_PARAMS];
  logic [WIDTH-1:0] shadow_d [NUM_PARAMS];
  logic             valid_q, valid_d;
  logic [IW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       cnt_q, cnt_d;

  logic any_press, do_short, step_up, step_dn;

  // Input arbitration: long beats short, any press discards steps, opposing
  // steps cancel.
  always_comb begin
    any_press = press_short | press_long;
    do_short  = press_short & ~press_long;
    step_up   = step_cw & ~step_ccw & ~any_press;
    step_dn   = step_ccw & ~step_cw & ~any_press;
  end

  // Next-state logic for the browse/edit/commit FSM and its datapath.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    edit_d   = edit_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      StBrowse: begin
        if (do_short) begin
          edit_d  = shadow_q[sel_q];
          state_d = StEdit;
        end else if (step_up) begin
          sel_d = sel_q + IW'(1);
        end else if (step_dn) begin
          sel_d = sel_q - IW'(1);
        end
      end
      StEdit: begin
        if (press_long) begin
          state_d = StBrowse;
        end else if (do_short) begin
          shadow_d[sel_q] = edit_q;
          valid_d         = 1'b1;
          addr_d          = sel_q;
          data_d          = edit_q;
          state_d         = StCommit;
        end else if (step_up) begin
          if (edit_q < ValMax) edit_d = edit_q + WIDTH'(1);
        end else if (step_dn) begin
          if (edit_q > ValMin) edit_d = edit_q - WIDTH'(1);
        end
      end
      StCommit: begin
        if (valid_q && cfg_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = StBrowse;
        end
      end
      default: state_d = StBrowse;
    endcase
  end

  // State registers; reset drops any pending write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBrowse;
      sel_q   <= '0;
      edit_q  <= ValReset;
      for (int i = 0; i < NUM_PARAMS; i++) shadow_q[i] <= ValReset;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      edit_q   <= edit_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs come straight from registers; display muxes shadow vs edit value.
  always_comb begin
    cfg_valid  = valid_q;
    cfg_addr   = addr_q;
    cfg_data   = data_q;
    mode       = state_q;
    sel_idx    = sel_q;
    commit_cnt = cnt_q;
    disp_val   = (state_q == StBrowse) ? shadow_q[sel_q] : edit_q;
  end

endmodule

// File: tb/tb_enc_param_ctrl.sv
// Directed self-checking bench for enc_param_ctrl (default parameters).
module tb_enc_param_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_cw = 1'b0, step_ccw = 1'b0, press_short = 1'b0, press_long = 1'b0;
  logic       cfg_ready = 1'b0;
  logic       cfg_valid;
  logic [1:0] cfg_addr, sel_idx, mode;
  logic [7:0] cfg_data, disp_val, commit_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic watch = 1'b0;
  logic saw_valid = 1'b0;

  enc_param_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .step_cw     (step_cw),
    .step_ccw    (step_ccw),
    .press_short (press_short),
    .press_long  (press_long),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .mode        (mode),
    .sel_idx     (sel_idx),
    .disp_val    (disp_val),
    .commit_cnt  (commit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (watch && cfg_valid) saw_valid = 1'b1;

  // One-cycle input pulse; outputs are settled 1 time unit after the edge.
  task automatic drive(input logic cw, input logic ccw, input logic ps, input logic pl);
    @(negedge clk);
    step_cw = cw; step_ccw = ccw; press_short = ps; press_long = pl;
    @(posedge clk);
    #1;
    step_cw = 1'b0; step_ccw = 1'b0; press_short = 1'b0; press_long = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (mode !== 2'b00 || sel_idx !== 2'd0 || disp_val !== 8'd0 || cfg_valid !== 1'b0 ||
        commit_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: mode=%0d sel=%0d disp=%0d valid=%0b cnt=%0d, want 0 0 0 0 0",
               mode, sel_idx, disp_val, cfg_valid, commit_cnt);
    end
  endtask

  task automatic test_browse_wrap();
    repeat (3) drive(1, 0, 0, 0);
    n_checks++;
    if (sel_idx !== 2'd3) begin
      n_fail++; $display("FAIL browse_cw3: sel=%0d want 3", sel_idx);
    end
    drive(1, 0, 0, 0);
    n_checks++;
    if (sel_idx !== 2'd0) begin
      n_fail++; $display("FAIL browse_wrap_up: sel=%0d want 0", sel_idx);
    end
    drive(0, 1, 0, 0);
    n_checks++;
    if (sel_idx !== 2'd3) begin
      n_fail++; $display("FAIL browse_wrap_dn: sel=%0d want 3", sel_idx);
    end
  endtask

  task automatic test_edit_commit();
    drive(0, 1, 0, 0);
    n_checks++;
    if (sel_idx !== 2'd2) begin
      n_fail++; $display("FAIL sel_to_2: sel=%0d want 2", sel_idx);
    end
    drive(0, 0, 1, 0);
    n_checks++;
    if (mode !== 2'b01 || disp_val !== 8'd0) begin
      n_fail++; $display("FAIL enter_edit: mode=%0d disp=%0d want 1 0", mode, disp_val);
    end
    repeat (20) drive(1, 0, 0, 0);
    n_checks++;
    if (disp_val !== 8'd15) begin
      n_fail++; $display("FAIL sat_max: disp=%0d want 15", disp_val);
    end
    drive(0, 0, 1, 0);
    n_checks++;
    if (mode !== 2'b10 || cfg_valid !== 1'b1 || cfg_addr !== 2'd2 || cfg_data !== 8'd15) begin
      n_fail++;
      $display("FAIL commit_start: mode=%0d valid=%0b addr=%0d data=%0d want 2 1 2 15",
               mode, cfg_valid, cfg_addr, cfg_data);
    end
    // Hold without ready; steps and presses in COMMIT must be ignored.
    for (int i = 0; i < 5; i++) begin
      drive(i == 1, i == 2, i == 3, i == 4);
      n_checks++;
      if (cfg_valid !== 1'b1 || cfg_addr !== 2'd2 || cfg_data !== 8'd15 || mode !== 2'b10 ||
          sel_idx !== 2'd2 || disp_val !== 8'd15) begin
        n_fail++;
        $display("FAIL commit_hold[%0d]: valid=%0b addr=%0d data=%0d mode=%0d sel=%0d disp=%0d",
                 i, cfg_valid, cfg_addr, cfg_data, mode, sel_idx, disp_val);
      end
    end
    @(negedge clk);
    cfg_ready = 1'b1;
    @(posedge clk);
    #1;
    cfg_ready = 1'b0;
    n_checks++;
    if (cfg_valid !== 1'b0 || mode !== 2'b00 || commit_cnt !== 8'd1 || disp_val !== 8'd15) begin
      n_fail++;
      $display("FAIL handshake: valid=%0b mode=%0d cnt=%0d disp=%0d want 0 0 1 15",
               cfg_valid, mode, commit_cnt, disp_val);
    end
    // Ready without valid must not count.
    @(negedge clk);
    cfg_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cfg_ready = 1'b0;
    n_checks++;
    if (commit_cnt !== 8'd1 || cfg_valid !== 1'b0) begin
      n_fail++; $display("FAIL ready_idle: cnt=%0d valid=%0b want 1 0", commit_cnt, cfg_valid);
    end
  endtask

  task automatic test_cancel();
    saw_valid = 1'b0;
    watch = 1'b1;
    drive(0, 0, 1, 0);
    repeat (3) drive(0, 1, 0, 0);
    n_checks++;
    if (disp_val !== 8'd12) begin
      n_fail++; $display("FAIL edit_dec: disp=%0d want 12", disp_val);
    end
    drive(0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    watch = 1'b0;
    n_checks++;
    if (mode !== 2'b00 || disp_val !== 8'd15 || saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel: mode=%0d disp=%0d saw_valid=%0b want 0 15 0",
               mode, disp_val, saw_valid);
    end
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 0, 0);
    n_checks++;
    if (sel_idx !== 2'd2 || mode !== 2'b00) begin
      n_fail++; $display("FAIL both_steps_browse: sel=%0d mode=%0d want 2 0", sel_idx, mode);
    end
    drive(1, 0, 1, 0);
    n_checks++;
    if (mode !== 2'b01 || sel_idx !== 2'd2 || disp_val !== 8'd15) begin
      n_fail++;
      $display("FAIL press_beats_step: mode=%0d sel=%0d disp=%0d want 1 2 15",
               mode, sel_idx, disp_val);
    end
    drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    n_checks++;
    if (disp_val !== 8'd14) begin
      n_fail++; $display("FAIL both_steps_edit: disp=%0d want 14", disp_val);
    end
    drive(0, 0, 1, 1);
    n_checks++;
    if (mode !== 2'b00 || cfg_valid !== 1'b0 || disp_val !== 8'd15) begin
      n_fail++;
      $display("FAIL long_beats_short: mode=%0d valid=%0b disp=%0d want 0 0 15",
               mode, cfg_valid, disp_val);
    end
    // Lower saturation on an untouched slot.
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    repeat (2) drive(0, 1, 0, 0);
    n_checks++;
    if (disp_val !== 8'd0 || sel_idx !== 2'd3) begin
      n_fail++; $display("FAIL sat_min: disp=%0d sel=%0d want 0 3", disp_val, sel_idx);
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_reset_in_commit();
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    n_checks++;
    if (cfg_valid !== 1'b1 || cfg_data !== 8'd14 || cfg_addr !== 2'd2) begin
      n_fail++;
      $display("FAIL commit2_start: valid=%0b data=%0d addr=%0d want 1 14 2",
               cfg_valid, cfg_data, cfg_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (cfg_valid !== 1'b0 || mode !== 2'b00 || commit_cnt !== 8'd0 || cfg_data !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0b mode=%0d cnt=%0d data=%0d want 0 0 0 0",
               cfg_valid, mode, commit_cnt, cfg_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (disp_val !== 8'd0 || sel_idx !== 2'(i)) begin
        n_fail++;
        $display("FAIL shadow_cleared[%0d]: disp=%0d sel=%0d want 0 %0d", i, disp_val,
                 sel_idx, i);
      end
      drive(1, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_browse_wrap();
    test_edit_commit();
    test_cancel();
    test_simultaneous();
    test_reset_in_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
